// File: rtl/pipe_stage_4_mem_pkg.sv
// Shared definitions for the MEM pipeline stage: control-word bit map, condition
// and size codes, FSM states and flag positions.
package pipe_pkg;

  localparam int M_RD      = 0;
  localparam int M_WR      = 1;
  localparam int M_BR      = 2;
  localparam int M_JMP     = 3;
  localparam int M_POP     = 4;
  localparam int M_COND_LO = 5;
  localparam int M_COND_HI = 7;
  localparam int M_SIZE_LO = 8;
  localparam int M_SIZE_HI = 9;
  localparam int M_SEXT    = 10;

  localparam int F_C = 3;
  localparam int F_V = 2;
  localparam int F_N = 1;
  localparam int F_Z = 0;

  typedef enum logic [2:0] {
    COND_EQ = 3'd0,
    COND_NE = 3'd1,
    COND_LT = 3'd2,
    COND_GE = 3'd3,
    COND_CS = 3'd4,
    COND_CC = 3'd5,
    COND_AL = 3'd6,
    COND_NV = 3'd7
  } cond_e;

  typedef enum logic [1:0] {
    SZ_W = 2'd0,
    SZ_H = 2'd1,
    SZ_B = 2'd2
  } size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    PC_SEQ = 2'd0,
    PC_BR  = 2'd1,
    PC_JMP = 2'd2
  } pc_sel_e;

  function automatic logic cond_eval(input logic [2:0] cond, input logic [3:0] flags);
    logic r;
    case (cond_e'(cond))
      COND_EQ: r = flags[F_Z];
      COND_NE: r = ~flags[F_Z];
      COND_LT: r = flags[F_N] ^ flags[F_V];
      COND_GE: r = ~(flags[F_N] ^ flags[F_V]);
      COND_CS: r = flags[F_C];
      COND_CC: r = ~flags[F_C];
      COND_AL: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pipe_stage_4_mem_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and the data memory (slave).
interface pipe_stage_4_mem_if #(
  parameter int AW = 32
) ();

  logic          dmem_req;
  logic          dmem_we;
  logic [3:0]    dmem_be;
  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_wdata;
  logic [31:0]   dmem_rdata;
  logic          dmem_ack;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_be,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_rdata,
    input  dmem_ack
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_be,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_rdata,
    output dmem_ack
  );

endinterface

// File: rtl/pipe_stage_4_mem_lane_align.sv
// Byte-lane handling for data-memory accesses: byte enables, store-lane replication,
// load extract/extend and misalignment detection. Purely combinational.
module mem_lane_align
  import pipe_pkg::*;
(
  input  logic        rd,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [1:0]  alu_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_raw,
  output logic [3:0]  be,
  output logic [31:0] st_lane,
  output logic [31:0] ld_data,
  output logic        misaligned
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    be         = 4'b1111;
    st_lane    = st_data;
    misaligned = 1'b0;
    ld_byte    = 8'h00;
    ld_half    = 16'h0000;
    ld_data    = ld_raw;
    case (size)
      SZ_H: begin
        be         = alu_lo[1] ? 4'b1100 : 4'b0011;
        st_lane    = {2{st_data[15:0]}};
        misaligned = alu_lo[0];
        ld_half    = ld_raw[{alu_lo[1], 4'b0000} +: 16];
        if (rd) begin
          ld_data = {{16{sext & ld_half[15]}}, ld_half};
        end
      end
      SZ_B: begin
        be      = 4'b0001 << alu_lo;
        st_lane = {4{st_data[7:0]}};
        ld_byte = ld_raw[{alu_lo, 3'b000} +: 8];
        if (rd) begin
          ld_data = {{24{sext & ld_byte[7]}}, ld_byte};
        end
      end
      // word, and the unused size code treated as word
      default: begin
        misaligned = (alu_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/pipe_stage_4_mem.sv
// MEM stage of the 5-stage pipeline: data-memory handshake, branch/jump redirect and the MEM/WB register.
// state   | meaning
// ST_IDLE | nothing outstanding; an aligned rd/wr requests in the same cycle
// ST_WAIT | request issued, waiting for dmem_ack; bus driven from the captured copy
module pipe_stage_4_mem
  import pipe_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        EXMEM_M,
  input  logic [3:0]         EXMEM_WB,
  input  logic [31:0]        EXMEM_Baddr,
  input  logic [31:0]        EXMEM_Jaddr,
  input  logic [3:0]         EXMEM_FLAGS,
  input  logic [31:0]        EXMEM_ALU,
  input  logic [DW-1:0]      EXMEM_MData,
  input  logic [4:0]         EXMEM_Waddr,
  pipe_stage_4_mem_if.master dmem,
  output logic [DW-1:0]      M_Data,
  output logic               stall,
  output logic               Flush,
  output logic [1:0]         pc_sel,
  output logic               mem_fault,
  output logic [3:0]         MEMWB_WB,
  output logic [31:0]        MEMWB_ALU,
  output logic [DW-1:0]      MEMWB_MData,
  output logic [4:0]         MEMWB_Waddr
);

  state_e        state_q;
  state_e        state_d;
  pc_sel_e       pc_sel_d;
  logic          rd;
  logic          wr;
  logic          misaligned;
  logic          access;
  logic          req;
  logic          use_hold;
  logic          capture;
  logic          fault_now;
  logic [3:0]    lane_be;
  logic [31:0]   lane_wdata;
  logic [AW-1:0] word_addr;
  logic          hold_we;
  logic [3:0]    hold_be;
  logic [AW-1:0] hold_addr;
  logic [31:0]   hold_wdata;
  logic          unused_in;

  assign rd        = EXMEM_M[M_RD];
  assign wr        = EXMEM_M[M_WR];
  assign word_addr = {EXMEM_ALU[AW-1:2], 2'b00};
  // targets are muxed in IF by pc_sel; the flag-pop bit is consumed by EX
  assign unused_in = ^{EXMEM_Baddr, EXMEM_Jaddr, EXMEM_M[15:11], EXMEM_M[M_POP]};

  mem_lane_align u_align (
    .rd        (rd),
    .size      (EXMEM_M[M_SIZE_HI:M_SIZE_LO]),
    .sext      (EXMEM_M[M_SEXT]),
    .alu_lo    (EXMEM_ALU[1:0]),
    .st_data   (EXMEM_MData),
    .ld_raw    (dmem.dmem_rdata),
    .be        (lane_be),
    .st_lane   (lane_wdata),
    .ld_data   (M_Data),
    .misaligned(misaligned)
  );

  assign access = (rd | wr) & ~misaligned;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (access && !dmem.dmem_ack) state_d = ST_WAIT;
      ST_WAIT: if (dmem.dmem_ack) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req       = 1'b0;
    use_hold  = 1'b0;
    capture   = 1'b0;
    fault_now = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req       = access;
        capture   = access & ~dmem.dmem_ack;
        fault_now = (rd | wr) & misaligned;
      end
      ST_WAIT: begin
        req      = 1'b1;
        use_hold = 1'b1;
      end
      default: ;
    endcase
    // reset drops the request immediately, even mid-access
    if (rst) begin
      req = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_we    <= 1'b0;
      hold_be    <= 4'h0;
      hold_addr  <= '0;
      hold_wdata <= 32'h0;
    end else if (capture) begin
      hold_we    <= wr;
      hold_be    <= lane_be;
      hold_addr  <= word_addr;
      hold_wdata <= lane_wdata;
    end
  end

  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = req & (use_hold ? hold_we : wr);
  assign dmem.dmem_be    = use_hold ? hold_be : lane_be;
  assign dmem.dmem_addr  = use_hold ? hold_addr : word_addr;
  assign dmem.dmem_wdata = use_hold ? hold_wdata : lane_wdata;

  assign stall = req & ~dmem.dmem_ack;

  always_comb begin
    pc_sel_d = PC_SEQ;
    if (EXMEM_M[M_JMP]) begin
      pc_sel_d = PC_JMP;
    end else if (EXMEM_M[M_BR] && cond_eval(EXMEM_M[M_COND_HI:M_COND_LO], EXMEM_FLAGS)) begin
      pc_sel_d = PC_BR;
    end
  end

  assign pc_sel = pc_sel_d;
  assign Flush  = (pc_sel_d != PC_SEQ) & ~stall;

  // stalled cycles and faulted accesses both hand a bubble to WB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_fault   <= 1'b0;
      MEMWB_WB    <= 4'h0;
      MEMWB_ALU   <= 32'h0;
      MEMWB_MData <= '0;
      MEMWB_Waddr <= 5'h0;
    end else begin
      mem_fault <= fault_now;
      if (stall || fault_now) begin
        MEMWB_WB    <= 4'h0;
        MEMWB_ALU   <= 32'h0;
        MEMWB_MData <= '0;
        MEMWB_Waddr <= 5'h0;
      end else begin
        MEMWB_WB    <= EXMEM_WB;
        MEMWB_ALU   <= EXMEM_ALU;
        MEMWB_MData <= M_Data;
        MEMWB_Waddr <= EXMEM_Waddr;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_4_mem.sv
// Randomized bench for pipe_stage_4_mem against an arithmetic reference model of the MEM stage.
module tb_pipe_stage_4_mem;

  logic        clk;
  logic        rst;
  logic [15:0] EXMEM_M;
  logic [3:0]  EXMEM_WB;
  logic [31:0] EXMEM_Baddr;
  logic [31:0] EXMEM_Jaddr;
  logic [3:0]  EXMEM_FLAGS;
  logic [31:0] EXMEM_ALU;
  logic [31:0] EXMEM_MData;
  logic [4:0]  EXMEM_Waddr;
  logic [31:0] M_Data;
  logic        stall;
  logic        Flush;
  logic [1:0]  pc_sel;
  logic        mem_fault;
  logic [3:0]  MEMWB_WB;
  logic [31:0] MEMWB_ALU;
  logic [31:0] MEMWB_MData;
  logic [4:0]  MEMWB_Waddr;

  int n_checks = 0;
  int n_errors = 0;

  pipe_stage_4_mem_if #(.AW(32)) dmem ();

  pipe_stage_4_mem #(.AW(32), .DW(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .EXMEM_M    (EXMEM_M),
    .EXMEM_WB   (EXMEM_WB),
    .EXMEM_Baddr(EXMEM_Baddr),
    .EXMEM_Jaddr(EXMEM_Jaddr),
    .EXMEM_FLAGS(EXMEM_FLAGS),
    .EXMEM_ALU  (EXMEM_ALU),
    .EXMEM_MData(EXMEM_MData),
    .EXMEM_Waddr(EXMEM_Waddr),
    .dmem       (dmem),
    .M_Data     (M_Data),
    .stall      (stall),
    .Flush      (Flush),
    .pc_sel     (pc_sel),
    .mem_fault  (mem_fault),
    .MEMWB_WB   (MEMWB_WB),
    .MEMWB_ALU  (MEMWB_ALU),
    .MEMWB_MData(MEMWB_MData),
    .MEMWB_Waddr(MEMWB_Waddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_aligned(input logic [15:0] m, input logic [31:0] alu);
    int sz = int'(m[9:8]);
    if (sz == 2) return 1'b1;
    if (sz == 1) return (alu % 2) == 0;
    return (alu % 4) == 0;
  endfunction

  function automatic bit model_cond(input int c, input logic [3:0] f);
    bit cf = f[3];
    bit vf = f[2];
    bit nf = f[1];
    bit zf = f[0];
    case (c)
      0: return zf;
      1: return !zf;
      2: return nf != vf;
      3: return nf == vf;
      4: return cf;
      5: return !cf;
      6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int model_pc(input logic [15:0] m, input logic [3:0] f);
    if (m[3]) return 2;
    if (m[2] && model_cond(int'(m[7:5]), f)) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] model_be(input logic [15:0] m, input logic [31:0] alu);
    int sz = int'(m[9:8]);
    if (sz == 2) return 32'd1 << (alu % 4);
    if (sz == 1) return 32'd3 << (2 * ((alu / 2) % 2));
    return 32'd15;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [15:0] m, input logic [31:0] d);
    int sz = int'(m[9:8]);
    if (sz == 2) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [15:0] m, input logic [31:0] alu,
                                             input logic [31:0] rdata);
    logic [31:0] v;
    int sz = int'(m[9:8]);
    if (!m[0]) return rdata;
    if (sz == 2) begin
      v = (rdata >> (8 * (alu % 4))) & 32'hFF;
      if (m[10] && v >= 128) v = v - 32'd256;
    end else if (sz == 1) begin
      v = (rdata >> (16 * ((alu / 2) % 2))) & 32'hFFFF;
      if (m[10] && v >= 32768) v = v - 32'd65536;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  task automatic set_op(input logic [15:0] m, input logic [3:0] wb, input logic [3:0] flags,
                        input logic [31:0] alu, input logic [31:0] mdata, input logic [31:0] rdata);
    EXMEM_M         = m;
    EXMEM_WB        = wb;
    EXMEM_FLAGS     = flags;
    EXMEM_ALU       = alu;
    EXMEM_MData     = mdata;
    EXMEM_Baddr     = $urandom;
    EXMEM_Jaddr     = $urandom;
    EXMEM_Waddr     = 5'($urandom);
    dmem.dmem_rdata = rdata;
  endtask

  task automatic zero_inputs();
    EXMEM_M = '0; EXMEM_WB = '0; EXMEM_FLAGS = '0; EXMEM_ALU = '0; EXMEM_MData = '0;
    EXMEM_Baddr = '0; EXMEM_Jaddr = '0; EXMEM_Waddr = '0;
    dmem.dmem_rdata = '0;
    dmem.dmem_ack   = 1'b0;
  endtask

  // Called just after a rising edge with the op already on the EXMEM inputs.
  task automatic run_op(input int waits_in);
    bit acc, mis, stl;
    int waits, pc;
    logic [31:0] exp_ld;
    mis    = (EXMEM_M[0] || EXMEM_M[1]) && !model_aligned(EXMEM_M, EXMEM_ALU);
    acc    = (EXMEM_M[0] || EXMEM_M[1]) && !mis;
    waits  = acc ? waits_in : 0;
    pc     = model_pc(EXMEM_M, EXMEM_FLAGS);
    exp_ld = model_load(EXMEM_M, EXMEM_ALU, dmem.dmem_rdata);
    dmem.dmem_ack = acc && (waits == 0);
    for (int k = 0; k <= waits; k++) begin
      stl = acc && (k < waits);
      @(negedge clk);
      check_val("req", 32'(dmem.dmem_req), 32'(acc));
      check_val("stall", 32'(stall), 32'(stl));
      check_val("pc_sel", 32'(pc_sel), 32'(pc));
      check_val("flush", 32'(Flush), 32'((pc != 0) && !stl));
      check_val("m_data", M_Data, exp_ld);
      if (acc) begin
        check_val("we", 32'(dmem.dmem_we), 32'(EXMEM_M[1]));
        check_val("be", 32'(dmem.dmem_be), model_be(EXMEM_M, EXMEM_ALU));
        check_val("addr", dmem.dmem_addr, EXMEM_ALU & ~32'h3);
        check_val("wdata", dmem.dmem_wdata, model_wdata(EXMEM_M, EXMEM_MData));
      end
      @(posedge clk);
      #1;
      if (stl || mis) begin
        check_val("memwb_wb_bubble", 32'(MEMWB_WB), 32'h0);
        check_val("memwb_alu_bubble", MEMWB_ALU, 32'h0);
        check_val("memwb_mdata_bubble", MEMWB_MData, 32'h0);
        check_val("memwb_waddr_bubble", 32'(MEMWB_Waddr), 32'h0);
      end else begin
        check_val("memwb_wb", 32'(MEMWB_WB), 32'(EXMEM_WB));
        check_val("memwb_alu", MEMWB_ALU, EXMEM_ALU);
        check_val("memwb_mdata", MEMWB_MData, exp_ld);
        check_val("memwb_waddr", 32'(MEMWB_Waddr), 32'(EXMEM_Waddr));
      end
      check_val("mem_fault", 32'(mem_fault), 32'(mis));
      dmem.dmem_ack = acc && (k + 1 == waits);
    end
    dmem.dmem_ack = 1'b0;
  endtask

  initial begin
    logic [15:0] m;
    logic [31:0] a;
    rst = 1'b1;
    zero_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_req", 32'(dmem.dmem_req), 32'h0);
    check_val("rst_memwb_wb", 32'(MEMWB_WB), 32'h0);
    check_val("rst_memwb_alu", MEMWB_ALU, 32'h0);
    check_val("rst_fault", 32'(mem_fault), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // word store, zero-wait
    set_op(16'h0002, 4'h0, 4'h0, 32'h10, 32'hDEAD_BEEF, 32'h0);
    run_op(0);
    // signed byte load from lane 3 with three wait states
    set_op(16'h0601, 4'h3, 4'h0, 32'h13, 32'h0, 32'h8012_3456);
    run_op(3);
    check_val("t2_mdata", MEMWB_MData, 32'hFFFF_FF80);
    // branch EQ taken / not taken
    set_op(16'h0004, 4'h1, 4'b0001, 32'h0, 32'h0, 32'h0);
    run_op(0);
    set_op(16'h0004, 4'h1, 4'b0000, 32'h0, 32'h0, 32'h0);
    run_op(0);
    // misaligned half load
    set_op(16'h0101, 4'h3, 4'h0, 32'h21, 32'h0, 32'h1234_5678);
    run_op(0);
    // jump and branch with cond=always
    set_op(16'h00CC, 4'h1, 4'h0, 32'h0, 32'h0, 32'h0);
    run_op(0);

    // async reset right after MEM/WB has been loaded
    set_op(16'h0001, 4'h3, 4'h0, 32'h40, 32'h0, 32'hCAFE_F00D);
    run_op(0);
    #2;
    rst = 1'b1;
    zero_inputs();
    #1;
    check_val("async_rst_wb", 32'(MEMWB_WB), 32'h0);
    check_val("async_rst_alu", MEMWB_ALU, 32'h0);
    check_val("async_rst_mdata", MEMWB_MData, 32'h0);
    check_val("async_rst_waddr", 32'(MEMWB_Waddr), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // reset while in WAIT
    set_op(16'h0001, 4'h1, 4'h0, 32'h80, 32'h0, 32'h1111_2222);
    dmem.dmem_ack = 1'b0;
    @(negedge clk);
    check_val("wait_entry_req", 32'(dmem.dmem_req), 32'h1);
    check_val("wait_entry_stall", 32'(stall), 32'h1);
    @(posedge clk);
    #2;
    check_val("in_wait_req", 32'(dmem.dmem_req), 32'h1);
    rst = 1'b1;
    zero_inputs();
    #1;
    check_val("wait_rst_req", 32'(dmem.dmem_req), 32'h0);
    check_val("wait_rst_we", 32'(dmem.dmem_we), 32'h0);
    check_val("wait_rst_stall", 32'(stall), 32'h0);
    @(posedge clk);
    #1;
    check_val("wait_rst_memwb_wb", 32'(MEMWB_WB), 32'h0);
    check_val("wait_rst_fault", 32'(mem_fault), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    set_op(16'h0002, 4'h1, 4'h0, 32'h44, 32'h5555_AAAA, 32'h0);
    run_op(1);

    for (int i = 0; i < 250; i++) begin
      m = 16'($urandom);
      m[9:8] = 2'($urandom_range(0, 2));
      m[3] = ($urandom_range(0, 3) == 0);
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      set_op(m, 4'($urandom), 4'($urandom), a, $urandom, $urandom);
      run_op(int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
